// File: rtl/led_engine_mc.sv
// led_engine_mc: multi-channel LED pulse/blink engine.
//
// Each channel runs its own IDLE/ON/OFF sequencer. A channel can be a
// retriggerable one-shot, a counted burst, or a continuous blinker. All
// outputs are registered and are decoded from the next state, so no
// input reaches an output combinationally.
//
// Ports:
//   clk    - system clock, all logic on posedge
//   rst_n  - asynchronous active-low reset
//   trig   - per-channel start/retrigger (level, sampled every edge)
//   stop   - per-channel cancel, takes priority over trig
//   mode   - 2 bits per channel: 00 one-shot, 01 burst, 10 continuous,
//            11 behaves as one-shot; latched on trig
//   rep    - REPW bits per channel, burst pulse count (0 acts as 1);
//            latched on trig
//   led    - registered LED drive, polarity set by ACTIVE_LOW
//   busy   - channel is not idle
//   done   - one-cycle pulse when a sequence finishes on its own
module led_engine_mc #(
  parameter int          NCH        = 4,
  parameter int          CNTW       = 32,
  parameter int unsigned ON_CYC     = 12500000,
  parameter int unsigned OFF_CYC    = 12500000,
  parameter int          REPW       = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      trig,
  input  logic [NCH-1:0]      stop,
  input  logic [2*NCH-1:0]    mode,
  input  logic [REPW*NCH-1:0] rep,
  output logic [NCH-1:0]      led,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [1:0]      MODE_BURST = 2'b01;
  localparam logic [1:0]      MODE_CONT  = 2'b10;
  localparam logic [CNTW-1:0] ON_LOAD    = CNTW'(ON_CYC - 1);
  localparam logic [CNTW-1:0] OFF_LOAD   = CNTW'(OFF_CYC - 1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [REPW-1:0] REP_ONE    = REPW'(1);
  localparam logic            LED_ACT    = ~ACTIVE_LOW;
  localparam logic            LED_INACT  = ACTIVE_LOW;

  state_t          state  [NCH];
  logic [CNTW-1:0] cnt    [NCH];
  logic [REPW-1:0] left   [NCH];
  logic [1:0]      mode_q [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= {NCH{ACTIVE_LOW}};
      busy <= '0;
      done <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        left[i]   <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        done[i] <= 1'b0;
        if (stop[i]) begin
          // Cancel silently; harmless when already idle.
          state[i] <= IDLE;
          led[i]   <= LED_INACT;
          busy[i]  <= 1'b0;
        end else if (trig[i]) begin
          // Trigger wins over a completion on the same edge, so done
          // stays low and the new ON phase starts at full length.
          state[i]  <= ON;
          cnt[i]    <= ON_LOAD;
          mode_q[i] <= mode[2*i +: 2];
          left[i]   <= (rep[REPW*i +: REPW] == '0) ? '0
                                                  : rep[REPW*i +: REPW] - REP_ONE;
          led[i]    <= LED_ACT;
          busy[i]   <= 1'b1;
        end else begin
          case (state[i])
            ON: begin
              if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - CNT_ONE;
              end else if (mode_q[i] == MODE_CONT ||
                           (mode_q[i] == MODE_BURST && left[i] != '0)) begin
                state[i] <= OFF;
                cnt[i]   <= OFF_LOAD;
                if (mode_q[i] == MODE_BURST) left[i] <= left[i] - REP_ONE;
                led[i]   <= LED_INACT;
              end else begin
                // One-shot, reserved mode, or last burst pulse.
                state[i] <= IDLE;
                led[i]   <= LED_INACT;
                busy[i]  <= 1'b0;
                done[i]  <= 1'b1;
              end
            end
            OFF: begin
              if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - CNT_ONE;
              end else begin
                state[i] <= ON;
                cnt[i]   <= ON_LOAD;
                led[i]   <= LED_ACT;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_engine_mc.sv
// tb_led_engine_mc: self-checking bench for led_engine_mc.
// Two instances share stimulus: one active-low, one active-high LED drive.
module tb_led_engine_mc;
  localparam int          NCH  = 2;
  localparam int          CNTW = 8;
  localparam int          REPW = 4;
  localparam int unsigned ONC  = 4;
  localparam int unsigned OFFC = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] trig  = '0;
  logic [1:0] stop  = '0;
  logic [3:0] mode  = '0;
  logic [7:0] rep   = '0;
  logic [1:0] led_a, busy_a, done_a;
  logic [1:0] led_b, busy_b, done_b;

  led_engine_mc #(.NCH(NCH), .CNTW(CNTW), .ON_CYC(ONC), .OFF_CYC(OFFC),
                  .REPW(REPW), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .trig(trig), .stop(stop), .mode(mode),
    .rep(rep), .led(led_a), .busy(busy_a), .done(done_a));

  led_engine_mc #(.NCH(NCH), .CNTW(CNTW), .ON_CYC(ONC), .OFF_CYC(OFFC),
                  .REPW(REPW), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .trig(trig), .stop(stop), .mode(mode),
    .rep(rep), .led(led_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: each running channel knows how many cycles have passed
  // since its trigger; the waveform is a pure function of that age.
  bit         run [NCH];
  int         age [NCH];
  logic [1:0] mm  [NCH];
  int         np  [NCH];
  logic [1:0] e_act, e_busy, e_done;

  int lowcnt  [NCH];
  int donecnt [NCH];

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] s;
    logic [3:0] m;
    logic [7:0] r;
    logic [1:0] led;
    logic [1:0] busy;
    logic [1:0] done;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%b required=%b", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      run[c] = 1'b0;
      age[c] = 0;
    end
    e_act = '0; e_busy = '0; e_done = '0;
  endtask

  task automatic model_step();
    int n, per, fin;
    for (int c = 0; c < NCH; c++) begin
      if (stop[c]) run[c] = 1'b0;
      else if (trig[c]) begin
        run[c] = 1'b1;
        age[c] = 0;
        mm[c]  = mode[2*c +: 2];
        np[c]  = (rep[4*c +: 4] == 4'd0) ? 1 : int'(rep[4*c +: 4]);
      end else if (run[c]) age[c]++;
      e_act[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
      if (run[c]) begin
        per = ONC + OFFC;
        n   = (mm[c] == 2'b01) ? np[c] : 1;
        fin = (n - 1) * per + ONC;
        if (mm[c] != 2'b10 && age[c] == fin) begin
          e_done[c] = 1'b1;
          run[c]    = 1'b0;
        end else begin
          e_busy[c] = 1'b1;
          e_act[c]  = ((age[c] % per) < ONC);
        end
      end
    end
  endtask

  task automatic compare_model();
    check("led_lo",  {6'b0, led_a},  {6'b0, ~e_act});
    check("led_hi",  {6'b0, led_b},  {6'b0, e_act});
    check("busy_lo", {6'b0, busy_a}, {6'b0, e_busy});
    check("busy_hi", {6'b0, busy_b}, {6'b0, e_busy});
    check("done_lo", {6'b0, done_a}, {6'b0, e_done});
    check("done_hi", {6'b0, done_b}, {6'b0, e_done});
  endtask

  task automatic step(input logic [1:0] t, input logic [1:0] s,
                      input logic [3:0] m, input logic [7:0] r);
    trig = t; stop = s; mode = m; rep = r;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    compare_model();
    for (int c = 0; c < NCH; c++) begin
      if (led_a[c] == 1'b0) lowcnt[c]++;
      if (done_a[c]) donecnt[c]++;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      lowcnt[c]  = 0;
      donecnt[c] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(2'b00, 2'b00, 4'h0, 8'h00);
  endtask

  task automatic add(input logic [1:0] t, input logic [1:0] s, input logic [3:0] m,
                     input logic [7:0] r, input logic [1:0] l, input logic [1:0] b,
                     input logic [1:0] d);
    vec_t v;
    v.t = t; v.s = s; v.m = m; v.r = r; v.led = l; v.busy = b; v.done = d;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic [1:0] l, input logic [1:0] b);
    for (int j = 0; j < n; j++) add(2'b00, 2'b00, 4'h0, 8'h00, l, b, 2'b00);
  endtask

  initial begin
    model_reset();
    clear_counts();

    // One-shot on ch0: four active cycles, done on the return edge.
    add(2'b01, 2'b00, 4'h0, 8'h00, 2'b10, 2'b01, 2'b00);
    add_idle(3, 2'b10, 2'b01);
    add(2'b00, 2'b00, 4'h0, 8'h00, 2'b11, 2'b00, 2'b01);
    add_idle(1, 2'b11, 2'b00);
    // Stop together with trig from idle: stays idle.
    add(2'b01, 2'b01, 4'h0, 8'h00, 2'b11, 2'b00, 2'b00);
    add_idle(1, 2'b11, 2'b00);
    // Reserved mode on ch1 behaves as one-shot.
    add(2'b10, 2'b00, 4'hC, 8'h00, 2'b01, 2'b10, 2'b00);
    add_idle(3, 2'b01, 2'b10);
    add(2'b00, 2'b00, 4'h0, 8'h00, 2'b11, 2'b00, 2'b10);
    add_idle(1, 2'b11, 2'b00);
    // Burst with rep=0 gives a single pulse.
    add(2'b01, 2'b00, 4'h1, 8'h00, 2'b10, 2'b01, 2'b00);
    add_idle(3, 2'b10, 2'b01);
    add(2'b00, 2'b00, 4'h0, 8'h00, 2'b11, 2'b00, 2'b01);
    add_idle(1, 2'b11, 2'b00);
    // Retrigger on the completion edge: no done, fresh pulse.
    add(2'b01, 2'b00, 4'h0, 8'h00, 2'b10, 2'b01, 2'b00);
    add_idle(3, 2'b10, 2'b01);
    add(2'b01, 2'b00, 4'h0, 8'h00, 2'b10, 2'b01, 2'b00);
    add_idle(3, 2'b10, 2'b01);
    add(2'b00, 2'b00, 4'h0, 8'h00, 2'b11, 2'b00, 2'b01);
    // Stop while idle does nothing.
    add(2'b00, 2'b11, 4'h0, 8'h00, 2'b11, 2'b00, 2'b00);

    // Reset with clocks running.
    repeat (2) @(posedge clk);
    #1;
    check("rst_led_lo", {6'b0, led_a},  8'h03);
    check("rst_led_hi", {6'b0, led_b},  8'h00);
    check("rst_busy",   {6'b0, busy_a}, 8'h00);
    check("rst_done",   {6'b0, done_a}, 8'h00);
    #3 rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].s, tbl[i].m, tbl[i].r);
      check($sformatf("tbl%0d_led", i),  {6'b0, led_a},  {6'b0, tbl[i].led});
      check($sformatf("tbl%0d_busy", i), {6'b0, busy_a}, {6'b0, tbl[i].busy});
      check($sformatf("tbl%0d_done", i), {6'b0, done_a}, {6'b0, tbl[i].done});
    end

    // Burst rep=3 on ch0: 3 pulses of 4, gaps of 3, one done.
    clear_counts();
    step(2'b01, 2'b00, 4'h1, 8'h03);
    idle(24);
    check("burst3_low",  8'(lowcnt[0]), 8'd12);
    check("burst3_done", 8'(donecnt[0]), 8'd1);
    check("burst3_ch1",  8'(lowcnt[1] + donecnt[1]), 8'd0);

    // Continuous on ch0, stopped during an OFF phase.
    clear_counts();
    step(2'b01, 2'b00, 4'h2, 8'h00);
    idle(18);
    check("cont_low", 8'(lowcnt[0]), 8'd12);
    check("cont_in_off", {7'b0, led_a[0]}, 8'd1);
    step(2'b00, 2'b01, 4'h0, 8'h00);
    check("stop_busy", {7'b0, busy_a[0]}, 8'd0);
    check("stop_led",  {7'b0, led_a[0]}, 8'd1);
    idle(8);
    check("stop_nodone", 8'(donecnt[0]), 8'd0);
    // Stop and trig together while blinking.
    step(2'b01, 2'b00, 4'h2, 8'h00);
    step(2'b01, 2'b01, 4'h2, 8'h00);
    check("stoptrig_busy", {7'b0, busy_a[0]}, 8'd0);
    idle(3);

    // Retrigger one-shot during ON cycle 3: 7 active cycles, one done.
    clear_counts();
    step(2'b01, 2'b00, 4'h0, 8'h00);
    idle(2);
    step(2'b01, 2'b00, 4'h0, 8'h00);
    idle(6);
    check("retrig_low",  8'(lowcnt[0]), 8'd7);
    check("retrig_done", 8'(donecnt[0]), 8'd1);

    // Both channels together: ch0 burst rep=2, ch1 one-shot.
    clear_counts();
    step(2'b11, 2'b00, 4'b0001, 8'h02);
    idle(14);
    check("indep_low0",  8'(lowcnt[0]), 8'd8);
    check("indep_done0", 8'(donecnt[0]), 8'd1);
    check("indep_low1",  8'(lowcnt[1]), 8'd4);
    check("indep_done1", 8'(donecnt[1]), 8'd1);

    // Randomised traffic against the model.
    for (int j = 0; j < 400; j++) begin
      logic [1:0] t, s;
      logic [7:0] r;
      t = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      s = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
      r = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      step(t, s, 4'($urandom), r);
    end

    // Asynchronous reset in the middle of a burst.
    step(2'b11, 2'b00, 4'b0101, 8'h33);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led_lo", {6'b0, led_a},  8'h03);
    check("arst_led_hi", {6'b0, led_b},  8'h00);
    check("arst_busy",   {6'b0, busy_a}, 8'h00);
    check("arst_done",   {6'b0, done_a}, 8'h00);
    model_reset();
    for (int j = 0; j < 10; j++) step(2'b11, 2'b00, 4'b0101, 8'h33);
    #3 rst_n = 1'b1;
    step(2'b00, 2'b00, 4'h0, 8'h00);
    step(2'b01, 2'b00, 4'h0, 8'h00);
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
